// File: rtl/main_memory_pkg.sv
// Shared constants for the main memory responder: data word width, the MMIO
// page (upper address byte) and the register offsets inside that page.
package main_memory_pkg;

    localparam int unsigned WORD_W = 16;

    // Upper address byte selecting the memory-mapped register page.
    localparam logic [7:0] MMIO_BASE = 8'hFF;

    // Register offsets (low address byte) within the MMIO page.
    localparam logic [7:0] OFF_PORT    = 8'h00; // output port, R/W
    localparam logic [7:0] OFF_CYCLE   = 8'h01; // cycle counter, R/W
    localparam logic [7:0] OFF_SCRATCH = 8'h02; // scratch, R/W
    localparam logic [7:0] OFF_STORES  = 8'h03; // store counter, read-only

    function automatic logic is_mmio(input logic [7:0] page);
        return page == MMIO_BASE;
    endfunction

endpackage

// File: rtl/main_memory_responder_mmio_regs.sv
// mmio_regs: memory-mapped register file of the main memory responder.
// Holds the output port, the free-running cycle counter, a scratch register
// and the saturating store counter, plus the write-first read mux.
//   clk, rst_n    : clock, asynchronous active-low reset
//   store_strobe  : any store this cycle (RAM or MMIO), feeds the store counter
//   mmio_we       : store aimed at the MMIO page this cycle
//   offset        : low address byte (register select)
//   wr_data       : store data
//   rd_data       : combinational read data for the addressed register
//   port_out      : output port register
//   cycle_count   : cycle counter register
module mmio_regs
    import main_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_strobe,
    input  logic              mmio_we,
    input  logic [7:0]        offset,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] port_out,
    output logic [WORD_W-1:0] cycle_count
);

    logic [WORD_W-1:0] port_d,    port_q;
    logic [WORD_W-1:0] cycle_d,   cycle_q;
    logic [WORD_W-1:0] scratch_d, scratch_q;
    logic [WORD_W-1:0] stores_d,  stores_q;

    always_comb begin
        port_d    = port_q;
        cycle_d   = cycle_q + 1'b1;
        scratch_d = scratch_q;
        stores_d  = stores_q;

        // Every strobe counts, including ones whose target discards them.
        if (store_strobe && (stores_q != '1)) begin
            stores_d = stores_q + 1'b1;
        end

        if (mmio_we) begin
            case (offset)
                OFF_PORT:    port_d    = wr_data;
                OFF_CYCLE:   cycle_d   = wr_data; // load replaces this cycle's increment
                OFF_SCRATCH: scratch_d = wr_data;
                default: ;                        // store counter and unmapped: discarded
            endcase
        end
    end

    // Write-first: a same-edge store to a writable register returns the new data.
    // The store counter is read-only, so its read always shows the pre-edge count.
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_PORT:    rd_data = mmio_we ? wr_data : port_q;
            OFF_CYCLE:   rd_data = mmio_we ? wr_data : cycle_q;
            OFF_SCRATCH: rd_data = mmio_we ? wr_data : scratch_q;
            OFF_STORES:  rd_data = stores_q;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q    <= '0;
            cycle_q   <= '0;
            scratch_q <= '0;
            stores_q  <= '0;
        end else begin
            port_q    <= port_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            stores_q  <= stores_d;
        end
    end

    assign port_out    = port_q;
    assign cycle_count = cycle_q;

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: single-cycle memory slave for a core's memory stage.
// Decodes each address to either the RAM (2^ADDR_BITS 16-bit words, upper
// address bits alias) or the MMIO page 0xFFxx, and returns registered load
// data one cycle later. No handshake: it answers every cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   address_from_core   : word address
//   data_from_core      : store data
//   write_en_from_core  : store strobe
//   data_to_core        : registered load data (write-first)
//   port_out            : MMIO output port register
//   cycle_count         : free-running cycle counter
module main_memory_responder
    import main_memory_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] address_from_core,
    input  logic [WORD_W-1:0] data_from_core,
    input  logic              write_en_from_core,
    output logic [WORD_W-1:0] data_to_core,
    output logic [WORD_W-1:0] port_out,
    output logic [WORD_W-1:0] cycle_count
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic                 mmio_sel;
    logic                 mmio_we;
    logic                 ram_we;
    logic                 store_strobe;
    logic [ADDR_BITS-1:0] ram_idx;
    logic [WORD_W-1:0]    mmio_rd;
    logic [WORD_W-1:0]    data_to_core_d, data_to_core_q;

    logic [WORD_W-1:0]    mem_q [DEPTH];

    assign mmio_sel = is_mmio(address_from_core[WORD_W-1:WORD_W-8]);
    assign ram_idx  = address_from_core[ADDR_BITS-1:0];

    // The register file ignores strobes under reset by itself; the RAM has no
    // reset, so its write enable is gated explicitly.
    assign store_strobe = write_en_from_core;
    assign mmio_we      = write_en_from_core & mmio_sel;
    assign ram_we       = write_en_from_core & ~mmio_sel & rst_n;

    mmio_regs u_mmio_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .store_strobe (store_strobe),
        .mmio_we      (mmio_we),
        .offset       (address_from_core[7:0]),
        .wr_data      (data_from_core),
        .rd_data      (mmio_rd),
        .port_out     (port_out),
        .cycle_count  (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= data_from_core;
        end
    end

    always_comb begin
        data_to_core_d = '0;
        if (mmio_sel) begin
            data_to_core_d = mmio_rd;
        end else if (write_en_from_core) begin
            data_to_core_d = data_from_core;
        end else begin
            data_to_core_d = mem_q[ram_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_to_core_q <= '0;
        end else begin
            data_to_core_q <= data_to_core_d;
        end
    end

    assign data_to_core = data_to_core_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural memory/register model, with a few
// literal expectations pinning known values.
module tb_main_memory_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic        wen;
    logic [15:0] data_to_core;
    logic [15:0] port_out;
    logic [15:0] cycle_count;

    main_memory_responder #(.ADDR_BITS(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .address_from_core  (addr),
        .data_from_core     (din),
        .write_en_from_core (wen),
        .data_to_core       (data_to_core),
        .port_out           (port_out),
        .cycle_count        (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state (written only by the stimulus process).
    logic [15:0] m_mem [256];
    bit          m_valid [256];
    logic [15:0] m_port, m_cyc, m_scr, m_st;
    logic [15:0] exp_data;
    bit          exp_dv;
    bit          chk_en;

    // Literal pins: stimulus bumps a sequence number, compare process checks once.
    int          pin_d_seq, pin_p_seq, pin_c_seq;
    logic [15:0] pin_d_val, pin_p_val, pin_c_val;
    string       pin_d_tag, pin_p_tag, pin_c_tag;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        m_port = '0; m_cyc = '0; m_scr = '0; m_st = '0;
        exp_data = '0; exp_dv = 1'b1;
    endtask

    // Apply one clock edge's worth of the rules to the model.
    task automatic model_edge(input logic [15:0] a, input logic [15:0] d, input bit we);
        logic [15:0] r;
        bit          dv;
        bit          mm;
        int          idx;
        dv  = 1'b1;
        mm  = (a[15:8] == 8'hFF);
        idx = int'(a[7:0]);
        if (mm) begin
            case (a[7:0])
                8'h00:   r = we ? d : m_port;
                8'h01:   r = we ? d : m_cyc;
                8'h02:   r = we ? d : m_scr;
                8'h03:   begin r = m_st; if (we) dv = 1'b0; end
                default: r = 16'h0000;
            endcase
        end else if (we) begin
            r = d;
        end else begin
            r  = m_mem[idx];
            dv = m_valid[idx];
        end
        m_cyc = (we && a == 16'hFF01) ? d : m_cyc + 16'd1;
        if (we && a == 16'hFF00) m_port = d;
        if (we && a == 16'hFF02) m_scr = d;
        if (we && m_st != 16'hFFFF) m_st = m_st + 16'd1;
        if (we && !mm) begin
            m_mem[idx]   = d;
            m_valid[idx] = 1'b1;
        end
        exp_data = r;
        exp_dv   = dv;
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input bit we);
        addr = a; din = d; wen = we;
        @(posedge clk);
        model_edge(a, d, we);
        #1;
    endtask

    task automatic pin_data(input string tag, input logic [15:0] v);
        pin_d_tag = tag; pin_d_val = v; pin_d_seq++;
    endtask
    task automatic pin_port(input string tag, input logic [15:0] v);
        pin_p_tag = tag; pin_p_val = v; pin_p_seq++;
    endtask
    task automatic pin_cyc(input string tag, input logic [15:0] v);
        pin_c_tag = tag; pin_c_val = v; pin_c_seq++;
    endtask

    // Compare process: the only place comparisons are made and counted.
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int seen_d = 0, seen_p = 0, seen_c = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("port_out", port_out, m_port);
            chk("cycle_count", cycle_count, m_cyc);
            if (exp_dv) chk("data_to_core", data_to_core, exp_data);
            if (pin_d_seq != seen_d) begin seen_d = pin_d_seq; chk(pin_d_tag, data_to_core, pin_d_val); end
            if (pin_p_seq != seen_p) begin seen_p = pin_p_seq; chk(pin_p_tag, port_out, pin_p_val); end
            if (pin_c_seq != seen_c) begin seen_c = pin_c_seq; chk(pin_c_tag, cycle_count, pin_c_val); end
        end
    end

    initial begin
        logic [15:0] a, d;
        bit          we;
        pin_d_seq = 0; pin_p_seq = 0; pin_c_seq = 0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        rst_n = 1'b0; addr = '0; din = '0; wen = 1'b0;
        model_reset();
        chk_en = 1'b1;
        pin_data("reset_data", 16'h0000);
        pin_port("reset_port", 16'h0000);
        pin_cyc("reset_cycle", 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        pin_cyc("reset_hold_cycle", 16'h0000);
        #2 rst_n = 1'b1;
        step(16'h0000, 16'h0000, 1'b0);
        pin_cyc("first_edge_cycle", 16'h0001);

        // RAM store then load.
        step(16'h0010, 16'hBEEF, 1'b1);
        step(16'h0010, 16'h0000, 1'b0);
        pin_data("ram_load", 16'hBEEF);
        // Aliasing and write-first.
        step(16'h0110, 16'h1234, 1'b1);
        step(16'h0010, 16'h0000, 1'b0);
        pin_data("alias_load", 16'h1234);
        step(16'h0020, 16'h5555, 1'b1);
        pin_data("ram_write_first", 16'h5555);
        // Cycle counter load and wrap.
        step(16'hFF01, 16'hFFFE, 1'b1);
        pin_cyc("cycle_load", 16'hFFFE);
        pin_data("cycle_write_first", 16'hFFFE);
        step(16'hFF01, 16'h0000, 1'b0);
        pin_cyc("cycle_inc", 16'hFFFF);
        pin_data("cycle_read_pre", 16'hFFFE);
        step(16'h0000, 16'h0000, 1'b0);
        pin_cyc("cycle_wrap", 16'h0000);
        // MMIO registers.
        step(16'hFF00, 16'h00A5, 1'b1);
        pin_port("port_store", 16'h00A5);
        pin_data("port_write_first", 16'h00A5);
        step(16'hFF03, 16'h1111, 1'b1);
        pin_port("store_cnt_write_ignored", 16'h00A5);
        step(16'hFF07, 16'h9999, 1'b1);
        pin_data("unmapped_write_read", 16'h0000);
        step(16'hFF07, 16'h0000, 1'b0);
        pin_data("unmapped_read", 16'h0000);
        step(16'hFF02, 16'hC0DE, 1'b1);
        step(16'hFF02, 16'h0000, 1'b0);
        pin_data("scratch_read", 16'hC0DE);

        // Reset asserted mid-store: everything clears at once.
        addr = 16'hFF00; din = 16'h7777; wen = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        pin_port("async_reset_port", 16'h0000);
        pin_cyc("async_reset_cycle", 16'h0000);
        pin_data("async_reset_data", 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 wen = 1'b0;
        #2 rst_n = 1'b1;
        step(16'hFF03, 16'h0000, 1'b0);
        pin_data("reset_store_cnt", 16'h0000);
        pin_cyc("release_first_edge", 16'h0001);
        // Three strobes to assorted addresses, then read the store counter.
        step(16'h0030, 16'hAAAA, 1'b1);
        step(16'hFF02, 16'h0102, 1'b1);
        step(16'hFF09, 16'h0304, 1'b1);
        step(16'hFF03, 16'h0000, 1'b0);
        pin_data("store_cnt_three", 16'h0003);

        // Randomized traffic; RAM addresses keep a small low-byte range for reuse.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                a = 16'hFF00 | 16'($urandom_range(0, 7));
            end else begin
                a = {8'($urandom_range(0, 254)), 2'b00, 6'($urandom)};
            end
            d  = 16'($urandom);
            we = ($urandom_range(0, 2) == 0);
            step(a, d, we);
        end
        wen = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
